// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory/I-O controller: sequences SRAM strobes for one access at a time and
// handles a single memory-mapped switch/hex-display address.
module slc3_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic [15:0] rdata,
    input  logic [15:0] S,
    output logic [15:0] hex_out,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data
);

    typedef enum logic [2:0] {
        StIdle,
        StIo,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;
    logic        drive;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    if (addr == IO_ADDR) begin
                        state_d = StIo;
                    end else if (!we) begin
                        state_d = StRd;
                    end else begin
                        state_d = StWrSetup;
                    end
                end
            end
            StIo: begin
                // S is sampled live here so the switch value is as late as possible
                if (we_q) begin
                    hex_d = wdata_q;
                end else begin
                    rdata_d = S;
                end
                state_d = StDone;
            end
            StRd: begin
                if (cnt_q == LastCnt) begin
                    rdata_d = Data;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrSetup: begin
                cnt_d   = '0;
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrHold: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        CE    = 1'b1;
        UB    = 1'b1;
        LB    = 1'b1;
        OE    = 1'b1;
        WE    = 1'b1;
        ADDR  = '0;
        drive = 1'b0;
        case (state_q)
            StRd: begin
                CE   = 1'b0;
                UB   = 1'b0;
                LB   = 1'b0;
                OE   = 1'b0;
                ADDR = {4'b0, addr_q};
            end
            StWrSetup, StWrHold: begin
                CE    = 1'b0;
                UB    = 1'b0;
                LB    = 1'b0;
                ADDR  = {4'b0, addr_q};
                drive = 1'b1;
            end
            StWrPulse: begin
                CE    = 1'b0;
                UB    = 1'b0;
                LB    = 1'b0;
                WE    = 1'b0;
                ADDR  = {4'b0, addr_q};
                drive = 1'b1;
            end
            StDone:  ready = 1'b1;
            default: ;
        endcase
    end

    assign Data    = drive ? wdata_q : 16'hzzzz;
    assign rdata   = rdata_q;
    assign hex_out = hex_q;

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Self-checking bench for slc3_mem_ctrl with a behavioural SRAM and a read-result scoreboard.
module tb_slc3_mem_ctrl;

    localparam logic [15:0] Keeper = 16'hA5C3;

    logic        Clk = 1'b0;
    logic        Reset, req, we;
    logic [15:0] addr, wdata, S;
    wire         ready, CE, UB, LB, OE, WE;
    wire  [15:0] rdata, hex_out;
    wire  [19:0] ADDR;
    wire  [15:0] Data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mem[0:1023];

    slc3_mem_ctrl #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .S(S), .hex_out(hex_out),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
    );

    always #5 Clk = ~Clk;

    // SRAM drives on reads; a known keeper pattern sits on the bus while deselected
    assign Data = (!CE && !OE && WE) ? mem[ADDR[9:0]] : (CE ? Keeper : 16'hzzzz);

    always @(posedge WE) begin
        if (!CE) mem[ADDR[9:0]] <= Data;
    end

    task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                              output int lat, output int ce_lo, output int oe_lo,
                              output int we_lo, output int bad_addr, output int bad_data,
                              output int bad_rd);
        lat = -1; ce_lo = 0; oe_lo = 0; we_lo = 0; bad_addr = 0; bad_data = 0; bad_rd = 0;
        @(negedge Clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge Clk);
        req = 1'b0; we = ~w; addr = 16'h0333; wdata = 16'h0000;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge Clk);
            if (!CE) begin
                ce_lo++;
                if (ADDR !== {4'h0, a}) bad_addr++;
                if (w && (Data !== d || OE !== 1'b1)) bad_data++;
                if (!w && Data !== mem[a[9:0]]) bad_rd++;
            end
            if (!OE) oe_lo++;
            if (!WE) we_lo++;
            if (ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; S = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            n_checks++;
            if ({ready, CE, UB, LB, OE, WE} !== 6'b011111 || Data !== Keeper) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got rdy/ce/ub/lb/oe/we=%b data=%h want 011111 %h",
                         i, {ready, CE, UB, LB, OE, WE}, Data, Keeper);
            end
        end
        n_checks++;
        if (rdata !== 16'h0 || hex_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got rdata=%h hex=%h want 0000 0000", rdata, hex_out);
        end
    endtask

    task automatic test_sram_read();
        int lat, ce_lo, oe_lo, we_lo, ba, bd, br;
        logic [15:0] e;
        exp_q.push_back(16'h1234);
        run_access(1'b0, 16'h0074, 16'h0000, lat, ce_lo, oe_lo, we_lo, ba, bd, br);
        n_checks++;
        if (lat !== 3 || ce_lo !== 2 || oe_lo !== 2 || we_lo !== 0) begin
            n_fail++;
            $display("FAIL rd_timing: got lat=%0d ce=%0d oe=%0d we=%0d want 3 2 2 0",
                     lat, ce_lo, oe_lo, we_lo);
        end
        n_checks++;
        if (ba !== 0 || br !== 0) begin
            n_fail++;
            $display("FAIL rd_bus: got bad_addr=%0d bad_data=%0d want 0 0", ba, br);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (rdata !== e) begin
            n_fail++;
            $display("FAIL rd_data: got %h want %h", rdata, e);
        end
    endtask

    task automatic test_sram_write();
        int lat, ce_lo, oe_lo, we_lo, ba, bd, br;
        logic [15:0] e;
        run_access(1'b1, 16'h0075, 16'hBEEF, lat, ce_lo, oe_lo, we_lo, ba, bd, br);
        n_checks++;
        if (lat !== 5 || we_lo !== 2 || ce_lo !== 4 || oe_lo !== 0) begin
            n_fail++;
            $display("FAIL wr_timing: got lat=%0d we=%0d ce=%0d oe=%0d want 5 2 4 0",
                     lat, we_lo, ce_lo, oe_lo);
        end
        n_checks++;
        if (ba !== 0 || bd !== 0) begin
            n_fail++;
            $display("FAIL wr_bus: got bad_addr=%0d bad_data=%0d want 0 0", ba, bd);
        end
        n_checks++;
        if (rdata !== 16'h1234 || mem[10'h075] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL wr_effect: got rdata=%h mem=%h want 1234 beef", rdata, mem[10'h075]);
        end
        exp_q.push_back(16'hBEEF);
        run_access(1'b0, 16'h0075, 16'h0000, lat, ce_lo, oe_lo, we_lo, ba, bd, br);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (rdata !== e || lat !== 3) begin
            n_fail++;
            $display("FAIL readback: got %h lat=%0d want %h lat=3", rdata, lat, e);
        end
    endtask

    task automatic test_io();
        int lat, ce_lo, oe_lo, we_lo, ba, bd, br;
        logic [15:0] e;
        S = 16'd74;
        exp_q.push_back(16'd74);
        run_access(1'b0, 16'hFFFF, 16'h0000, lat, ce_lo, oe_lo, we_lo, ba, bd, br);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (lat !== 2 || ce_lo !== 0 || oe_lo !== 0 || rdata !== e) begin
            n_fail++;
            $display("FAIL io_read: got lat=%0d ce=%0d oe=%0d rdata=%h want 2 0 0 %h",
                     lat, ce_lo, oe_lo, rdata, e);
        end
        run_access(1'b1, 16'hFFFF, 16'h00AB, lat, ce_lo, oe_lo, we_lo, ba, bd, br);
        n_checks++;
        if (lat !== 2 || ce_lo !== 0 || we_lo !== 0 || hex_out !== 16'h00AB) begin
            n_fail++;
            $display("FAIL io_write: got lat=%0d ce=%0d we=%0d hex=%h want 2 0 0 00ab",
                     lat, ce_lo, we_lo, hex_out);
        end
        n_checks++;
        if (rdata !== 16'd74 || mem[10'h3FF] !== 16'h0000) begin
            n_fail++;
            $display("FAIL io_side: got rdata=%h mem=%h want 004a 0000", rdata, mem[10'h3FF]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cur, e;
        int          pulses = 0;
        int          last = -10;
        int          bad_gap = 0;
        int          bad_addr = 0;
        int          bad_data = 0;
        logic        seen = 1'b0;
        @(negedge Clk);
        req = 1'b1; we = 1'b0; addr = 16'h0074; cur = 16'h0074;
        exp_q.push_back(mem[10'h074]);
        for (int i = 1; i <= 25; i++) begin
            @(negedge Clk);
            if (ready) begin
                pulses++;
                if (pulses > 1 && i - last !== 4) bad_gap++;
                last = i;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                if (rdata !== e) bad_data++;
                cur = (cur == 16'h0074) ? 16'h0075 : 16'h0074;
                addr = cur;
                exp_q.push_back(mem[cur[9:0]]);
            end else if (!CE) begin
                if (ADDR !== {4'h0, cur}) bad_addr++;
                addr = 16'h0200 + 16'(i);
            end
        end
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (ready) begin
                seen = 1'b1;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                if (rdata !== e) bad_data++;
                break;
            end
        end
        n_checks++;
        if (pulses !== 6 || bad_gap !== 0) begin
            n_fail++;
            $display("FAIL b2b_pulses: got pulses=%0d bad_gaps=%0d want 6 0", pulses, bad_gap);
        end
        n_checks++;
        if (bad_addr !== 0 || bad_data !== 0) begin
            n_fail++;
            $display("FAIL b2b_data: got bad_addr=%0d bad_rdata=%0d want 0 0", bad_addr, bad_data);
        end
        n_checks++;
        if (!seen || exp_q.size() !== 0 || hex_out !== 16'h00AB) begin
            n_fail++;
            $display("FAIL b2b_tail: got last_ready=%b pending=%0d hex=%h want 1 0 00ab",
                     seen, exp_q.size(), hex_out);
        end
    endtask

    task automatic test_reset_mid_write();
        logic found = 1'b0;
        int   extra = 0;
        @(negedge Clk);
        req = 1'b1; we = 1'b1; addr = 16'h0076; wdata = 16'h1357;
        @(negedge Clk);
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!WE) begin
                found = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_wr_reach: got no WE pulse want WE low within 10 cycles");
        end
        Reset = 1'b1;
        @(negedge Clk);
        n_checks++;
        if ({ready, CE, WE} !== 3'b011 || Data !== Keeper || hex_out !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_wr_abort: got rdy/ce/we=%b data=%h hex=%h want 011 %h 0000",
                     {ready, CE, WE}, Data, hex_out, Keeper);
        end
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (ready || !CE) extra++;
        end
        n_checks++;
        if (extra !== 0 || rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_wr_quiet: got activity=%0d rdata=%h want 0 0000", extra, rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h074] = 16'h1234;
        test_reset();
        test_sram_read();
        test_sram_write();
        test_io();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slc3_mem_ctrl.md
Name: slc3_mem_ctrl

Overview:
Memory/I-O controller between the SLC-3 datapath (MAR/MDR side) and the off-chip 16-bit SRAM plus the board switches and hex display.
Accepts one request at a time over a req/ready handshake and sequences SRAM control strobes with a programmable number of wait cycles.
Decodes one memory-mapped I/O address: reads return switch value S, writes load the hex display register.
Instantiated inside the SLC-3 top beside the datapath; drives the top-level CE/UB/LB/OE/WE/ADDR/Data pins.

Parameters:
WAIT_CYCLES, 2, SRAM access cycles (read strobe length / WE low width); legal range 1..15
IO_ADDR, 16'hFFFF, address decoded as switch/hex I/O instead of SRAM

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous reset, active-high
req  in  1  request strobe from datapath; sampled only in IDLE
we  in  1  1 = write, 0 = read; latched with req
addr  in  16  word address (MAR); latched with req
wdata  in  16  write data (MDR); latched with req
ready  out  1  one-cycle completion pulse
rdata  out  16  read result; holds until the next read completes
S  in  16  switch inputs
hex_out  out  16  hex display register
CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low
ADDR  out  20  SRAM address
Data  inout  16  SRAM data bus

Behaviour:
- Reset (any state): state=IDLE, ready=0, rdata=0, hex_out=0, CE=UB=LB=OE=WE=1, ADDR=0, Data=Z; any in-flight access is aborted with no ready pulse.
- States: IDLE, IO, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 4-bit counter counts RD and WR_PULSE cycles.
- IDLE: all strobes at 1, Data=Z. On an edge where req=1, latch addr, we, wdata and branch:
  - addr==IO_ADDR: go to IO.
  - we=0: go to RD.
  - we=1: go to WR_SETUP.
- IO, one cycle:
  - Read: rdata<=S, with S sampled at the end of the IO cycle.
  - Write: hex_out<=wdata.
  - Next state is DONE. No SRAM strobe asserts at any time.
- RD, WAIT_CYCLES cycles: CE=OE=UB=LB=0, WE=1, ADDR={4'b0,addr}, Data=Z. The edge ending the last RD cycle captures Data into rdata; next state is DONE.
- WR_SETUP, 1 cycle: CE=UB=LB=0, WE=1, OE=1; ADDR valid; Data driven with wdata.
- WR_PULSE, WAIT_CYCLES cycles: as WR_SETUP but with WE=0.
- WR_HOLD, 1 cycle: WE=1; CE, ADDR and Data stay as in WR_SETUP. Next state is DONE.
- Data is driven only in WR_SETUP, WR_PULSE and WR_HOLD; Z everywhere else. OE=1 in every write state.
- DONE, 1 cycle: ready=1, all strobes at 1, Data=Z. Always returns to IDLE.
- Latency, counted in cycles from the accepting edge to the cycle in which ready=1:
  - I/O: 2.
  - SRAM read: WAIT_CYCLES+1.
  - SRAM write: WAIT_CYCLES+3.
- req is ignored outside IDLE; a req held high through DONE is re-accepted in the following IDLE cycle. Minimum request spacing is one IDLE cycle.
- addr, we, wdata and S changes after acceptance do not affect the access in flight (S is used only in the IO cycle).
- rdata changes only at read completion. Writes never modify rdata, and SRAM reads never modify hex_out.
- ready is never high for two consecutive cycles.

Test Plan:
- Reset held 2 cycles, then released with req=0 -> ready=0, rdata=0, hex_out=0, CE/OE/WE=1, Data=Z for 10 cycles.
- WAIT_CYCLES=2; SRAM model holds 16'h1234 at 0x0074; req=1, we=0, addr=16'h0074 for one cycle -> CE=OE=0 and ADDR=20'h00074 for exactly 2 cycles, ready pulses in the 3rd cycle after acceptance, rdata=16'h1234.
- Write addr=16'h0075, wdata=16'hBEEF -> WE low exactly 2 cycles, Data=16'hBEEF from WR_SETUP through WR_HOLD, OE=1 throughout, ready in the 5th cycle; a read-back of 0x0075 returns 16'hBEEF.
- I/O: S=16'd0074, read addr=16'hFFFF -> ready in 2nd cycle, rdata=16'd0074, no CE assertion; then write 16'h00AB to 16'hFFFF -> hex_out=16'h00AB, SRAM untouched.
- req held high continuously for alternating reads -> exactly one ready pulse per access, separated by at least one IDLE cycle; addr changed mid-access has no effect on ADDR.
- Reset asserted during WR_PULSE -> next cycle WE=1, CE=1, Data=Z, no ready pulse; hex_out=0.
